mem_readout_arbiter: RTL and testbench
======================================

Name: mem_readout_arbiter

Overview:
Read-side sequencer for the 12-port priority-encoder demo. Per event it latches the entry counts of 12 memories and drains them in fixed priority order, lowest index first. It drives a one-hot read enable and a shared read address to the memories, and the 4-bit binary select to the downstream registered 12:1 data mux (mem_mux). It also generates valid/last flags aligned with the 45-bit stream that mem_mux outputs.

Parameters:
NMEM, 12, number of memory ports (fixed by the mux; not meant to be overridden)
NENT_W, 6, width of per-memory entry count and read address
MEM_LAT, 1, memory read latency in cycles from rd_en to data at mux input (>=1)
MAX_CYCLES, 108, read-issue budget per event in cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; new event, latch counts
nent_all  in  NMEM*NENT_W  packed entry counts, memory i at bits [i*NENT_W +: NENT_W]
rd_en  out  NMEM  one-hot read enable to memory i
rd_addr  out  NENT_W  read address, shared by all memories
sel  out  4  binary mux select, delayed to align with memory data
dat_valid  out  1  mux output word is valid this cycle
dat_last  out  1  final word of the event on mux output
busy  out  1  readout in progress (RUN state)
truncated  out  1  sticky per event; budget hit or aborted by start with entries pending

Behaviour:
- Reset values: rd_en=0, rd_addr=0, sel=4'h0, dat_valid=0, dat_last=0, busy=0, truncated=0. Reset also clears the remaining counts, cycle counter, delay pipes and the FSM, which returns to IDLE. Reset takes priority over start.
- FSM states: IDLE, RUN.
  - IDLE + start: latch nent_all into rem[0..11], clear cycle counter and truncated, go to RUN. If all counts are 0, stay in IDLE; no reads, no valid.
  - RUN, each cycle: pick the lowest i with rem[i]>0.
    - Register rd_en=1<<i and rd_addr=nent[i]-rem[i], so addresses run 0..n-1 per memory.
    - Decrement rem[i] and increment the cycle counter.
  - RUN exits to IDLE (busy falls next cycle) when the issued word empties all rem.
  - Budget: if the counter reaches MAX_CYCLES with any rem>0, set truncated=1, clear rem and go to IDLE. The final issued word carries the last tag.
  - start in RUN: set truncated=1, relatch counts, restart from memory 0 next cycle. Words already in the delay pipe still emerge with valid. The aborted readout gets no last tag.
- Index to sel encoding, fixed by the mux: indices 0..9 map to 4'h0..4'h9, index 10 to 4'hB, index 11 to 4'hC. 4'hA is never driven. 4'hF is reserved for a future header stream.
- Latency: rd_en/rd_addr asserted in cycle T.
  - sel carries that index's code in cycle T+MEM_LAT, when the memory data is at the mux inputs.
  - dat_valid (and dat_last, if tagged) is high in cycle T+MEM_LAT+1, aligned with the mux output.
- Throughput: one word per cycle with no bubbles, including across memory boundaries.
- sel holds its last value when idle; downstream qualifies the stream with dat_valid only.
- rd_en is zero in any cycle with no issue.

Decomposition:
- Shared package: NMEM, NENT_W, sel code constants (SEL_HDR=4'hF) and an index-to-sel function, shared with mem_mux and testbench.
- One sub-module: prio_enc12, combinational lowest-set-bit encoder over the rem>0 vector, outputs index and any-set.
- The delay pipes stay inline.

Test Plan:
- Counts: mem0=3, mem5=2, others 0; start at cycle 0. Expect:
  - rd_en 0x001 at cycles 1-3 with addresses 0,1,2, then rd_en 0x020 at cycles 4-5 with addresses 0,1.
  - With MEM_LAT=1: dat_valid at cycles 3-7 and dat_last at cycle 7; sel is 0,0,0,5,5 at cycles 2-6.
- Counts mem10=1, mem11=1: sel sequence 4'hB then 4'hC; 4'hA never appears.
- All 12 counts = 20 (240 words), MAX_CYCLES=108:
  - exactly 108 issues, memories 0-4 drained, mem5 addresses 0..7;
  - truncated=1; dat_last on the 108th valid.
- start again at cycle 50 of a readout: truncated=1; issues resume at mem0 address 0 the next cycle; in-flight words still valid; no dat_last for the aborted event.
- All counts zero plus start: busy, rd_en and dat_valid stay 0.
- Assert reset mid-RUN: next cycle all outputs equal their reset values and in-flight valids are dropped; a later start behaves normally.

Source files
------------

// File: rtl/mem_readout_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_readout_arbiter_pkg
// Purpose : shared constants, types and the memory-index to mux-select mapping
//           used by the readout arbiter, the downstream mem_mux and benches.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package mem_readout_arbiter_pkg;

  localparam int NMEM   = 12;  // memory ports, fixed by the 12:1 mux
  localparam int NENT_W = 6;   // entry count / read address width
  localparam int IDX_W  = 4;   // memory index width (also the select width)

  // Select codes. 4'hA is a hole in the mux decode and is never driven;
  // 4'hF is kept for a future header stream.
  localparam logic [3:0] SEL_UNUSED = 4'hA;
  localparam logic [3:0] SEL_HDR    = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One stage of the data-alignment pipe.
  typedef struct packed {
    logic       vld;
    logic       last;
    logic [3:0] sel;
  } pipe_t;

  // Memories 0..9 map straight through; 10 and 11 skip over code 4'hA.
  function automatic logic [3:0] idx_to_sel(input logic [IDX_W-1:0] idx);
    if (idx < 4'd10) begin
      return idx;
    end
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/mem_readout_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_readout_arbiter_if
// Purpose : groups the event trigger, memory read bus, mux select and stream
//           flags of the readout arbiter.
// Signals : start      - one-cycle event pulse
//           nent_all   - packed per-memory entry counts
//           rd_en      - one-hot memory read enable
//           rd_addr    - shared read address
//           sel        - binary select to mem_mux
//           dat_valid  - mux output word valid
//           dat_last   - final word of the event
//           busy       - readout in progress
//           truncated  - event cut short (budget or abort)
// Modports: master = arbiter side, slave = environment side.
// -----------------------------------------------------------------------------
interface mem_readout_arbiter_if;
  import mem_readout_arbiter_pkg::*;

  logic                     start;
  logic [NMEM*NENT_W-1:0]   nent_all;
  logic [NMEM-1:0]          rd_en;
  logic [NENT_W-1:0]        rd_addr;
  logic [3:0]               sel;
  logic                     dat_valid;
  logic                     dat_last;
  logic                     busy;
  logic                     truncated;

  modport master (
    input  start, nent_all,
    output rd_en, rd_addr, sel, dat_valid, dat_last, busy, truncated
  );

  modport slave (
    output start, nent_all,
    input  rd_en, rd_addr, sel, dat_valid, dat_last, busy, truncated
  );

endinterface

// File: rtl/mem_readout_arbiter_prio_enc12.sv
// -----------------------------------------------------------------------------
// prio_enc12
// Purpose : combinational lowest-set-bit encoder over 12 request lines.
// Ports   : i_req - request vector (bit i = memory i has entries left)
//           o_idx - index of the lowest set bit (0 when none set)
//           o_any - at least one request bit is set
// -----------------------------------------------------------------------------
module prio_enc12
  import mem_readout_arbiter_pkg::*;
(
  input  logic [NMEM-1:0]  i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NMEM - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_readout_arbiter.sv
// -----------------------------------------------------------------------------
// mem_readout_arbiter
// Purpose : per event, latch the entry counts of 12 memories and drain them
//           lowest index first, one word per cycle, under a per-event cycle
//           budget. Drives one-hot read enables and a shared address, the
//           mux select aligned with memory data, and valid/last flags aligned
//           with the registered mux output.
// Ports   : clk   - system clock
//           reset - synchronous active-high reset
//           bus   - mem_readout_arbiter_if.master (start, nent_all, rd_en,
//                   rd_addr, sel, dat_valid, dat_last, busy, truncated)
// Params  : MEM_LAT    - rd_en to data-at-mux-input latency (>= 1)
//           MAX_CYCLES - read-issue budget per event
// -----------------------------------------------------------------------------
module mem_readout_arbiter
  import mem_readout_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int MAX_CYCLES = 108
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_readout_arbiter_if.master bus
);

  localparam int               CNT_W   = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

  state_t                r_state, w_state_next;
  logic [NENT_W-1:0]     w_in_nent  [NMEM];
  logic [NENT_W-1:0]     r_nent     [NMEM];
  logic [NENT_W-1:0]     r_rem      [NMEM];
  logic [NENT_W-1:0]     w_base     [NMEM];
  logic [NENT_W-1:0]     w_len      [NMEM];
  logic [NENT_W-1:0]     w_rem_dec  [NMEM];
  logic [NENT_W-1:0]     w_rem_next [NMEM];
  logic [NMEM-1:0]       w_req, w_left_vec, w_pend_vec;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any, w_active, w_issue, w_left, w_pending;
  logic                  w_budget_hit, w_last;
  logic [CNT_W-1:0]      r_cnt, w_cnt_base, w_cnt_inc;
  logic [NENT_W-1:0]     w_addr;
  logic                  r_truncated, w_trunc_next;
  logic [NMEM-1:0]       r_rd_en;
  logic [NENT_W-1:0]     r_rd_addr;
  logic                  r_issue, r_last;
  logic [3:0]            r_code, r_sel;
  pipe_t                 w_stage0;
  pipe_t [MEM_LAT+1:1]   r_pipe;
  pipe_t [MEM_LAT+1:0]   w_all;

  // A start (in either state) replaces whatever is left with the new counts,
  // so the pick for the next cycle comes straight from nent_all.
  assign w_active   = bus.start || (r_state == ST_RUN);
  assign w_cnt_base = bus.start ? '0 : r_cnt;
  assign w_cnt_inc  = w_cnt_base + CNT_W'(1);

  generate
    for (genvar gi = 0; gi < NMEM; gi++) begin : g_mem
      assign w_in_nent[gi]  = bus.nent_all[gi*NENT_W +: NENT_W];
      assign w_base[gi]     = bus.start ? w_in_nent[gi] : r_rem[gi];
      assign w_len[gi]      = bus.start ? w_in_nent[gi] : r_nent[gi];
      assign w_req[gi]      = w_active && (w_base[gi] != '0);
      assign w_rem_dec[gi]  = (w_issue && (w_idx == IDX_W'(gi)))
                              ? w_base[gi] - NENT_W'(1) : w_base[gi];
      assign w_rem_next[gi] = w_budget_hit ? '0 : w_rem_dec[gi];
      assign w_left_vec[gi] = (w_rem_dec[gi] != '0);
      assign w_pend_vec[gi] = (r_rem[gi] != '0);
    end
  endgenerate

  prio_enc12 u_prio (
    .i_req (w_req),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_issue   = w_any;
  assign w_left    = |w_left_vec;
  assign w_pending = |w_pend_vec;

  // The issue that reaches the budget with work left ends the event early.
  assign w_budget_hit = w_issue && w_left && (w_cnt_inc == CNT_MAX);
  assign w_last       = w_issue && (!w_left || (w_cnt_inc == CNT_MAX));

  // Address counts up from 0: total entries minus entries still to read.
  always_comb begin
    w_addr = '0;
    for (int i = 0; i < NMEM; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_addr = w_len[i] - w_base[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_trunc_next = r_truncated;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_trunc_next = w_budget_hit;
          w_state_next = w_issue ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort flags the interrupted event only if it still had work.
        if (bus.start) begin
          w_trunc_next = w_pending || w_budget_hit;
        end else begin
          w_trunc_next = r_truncated || w_budget_hit;
        end
        w_state_next = w_issue ? ST_RUN : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Stage 0 is the issue on the memory bus this cycle; stage k is k cycles on.
  assign w_stage0 = '{vld: r_issue, last: r_last, sel: r_code};
  assign w_all    = {r_pipe, w_stage0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_truncated <= 1'b0;
      r_cnt       <= '0;
      r_issue     <= 1'b0;
      r_last      <= 1'b0;
      r_rd_en     <= '0;
      r_rd_addr   <= '0;
      r_code      <= '0;
      r_sel       <= '0;
      r_pipe      <= '0;
      for (int i = 0; i < NMEM; i++) begin
        r_rem[i]  <= '0;
        r_nent[i] <= '0;
      end
    end else begin
      r_state     <= w_state_next;
      r_truncated <= w_trunc_next;
      r_cnt       <= w_issue ? w_cnt_inc : w_cnt_base;
      r_issue     <= w_issue;
      r_last      <= w_last;
      r_rd_en     <= w_issue ? (NMEM'(1) << w_idx) : '0;
      if (w_issue) begin
        r_rd_addr <= w_addr;
        r_code    <= idx_to_sel(w_idx);
      end
      for (int i = 0; i < NMEM; i++) begin
        r_rem[i] <= w_rem_next[i];
        if (bus.start) begin
          r_nent[i] <= w_in_nent[i];
        end
      end
      r_pipe[1] <= w_stage0;
      for (int k = 2; k <= MEM_LAT + 1; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      // sel only moves for real words, so it holds while idle.
      if (w_all[MEM_LAT-1].vld) begin
        r_sel <= w_all[MEM_LAT-1].sel;
      end
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.sel       = r_sel;
  assign bus.dat_valid = w_all[MEM_LAT+1].vld;
  assign bus.dat_last  = w_all[MEM_LAT+1].vld && w_all[MEM_LAT+1].last;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.truncated = r_truncated;

endmodule

// File: tb/tb_mem_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_readout_arbiter
// Purpose : directed self-checking bench for mem_readout_arbiter
//           (MEM_LAT=1, MAX_CYCLES=108). Each event is logged cycle by cycle
//           (cycle 0 = the cycle start is high) and compared against
//           hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_mem_readout_arbiter;
  import mem_readout_arbiter_pkg::*;

  localparam int LOGN = 200;
  localparam int VW   = NMEM * NENT_W;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [NMEM-1:0]   lg_rd_en [LOGN];
  logic [NENT_W-1:0] lg_addr  [LOGN];
  logic [3:0]        lg_sel   [LOGN];
  logic              lg_val   [LOGN];
  logic              lg_last  [LOGN];
  logic              lg_busy  [LOGN];
  logic              lg_trunc [LOGN];

  mem_readout_arbiter_if bus ();

  mem_readout_arbiter #(
    .MEM_LAT    (1),
    .MAX_CYCLES (108)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with nent in cycle 0; optionally pulse again with nent2 at abort_at.
  task automatic run_event(input logic [VW-1:0] nent, input int ncyc,
                           input int abort_at, input logic [VW-1:0] nent2);
    bus.nent_all = nent;
    bus.start    = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == abort_at) begin
        bus.nent_all = nent2;
        bus.start    = 1'b1;
      end
      lg_rd_en[c] = bus.rd_en;
      lg_addr[c]  = bus.rd_addr;
      lg_sel[c]   = bus.sel;
      lg_val[c]   = bus.dat_valid;
      lg_last[c]  = bus.dat_last;
      lg_busy[c]  = bus.busy;
      lg_trunc[c] = bus.truncated;
      step();
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.nent_all = '0;
    step(); step(); step();
    checks++; if (bus.rd_en !== 12'h000) begin errors++; $display("FAIL reset_rd_en got %h exp 000", bus.rd_en); end
    checks++; if (bus.rd_addr !== 6'd0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", bus.rd_addr); end
    checks++; if (bus.sel !== 4'h0) begin errors++; $display("FAIL reset_sel got %h exp 0", bus.sel); end
    checks++; if (bus.dat_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.dat_valid); end
    checks++; if (bus.dat_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", bus.dat_last); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.truncated !== 1'b0) begin errors++; $display("FAIL reset_trunc got %b exp 0", bus.truncated); end
    reset = 1'b0;
    step();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_basic();
    logic [VW-1:0]     v;
    logic [NMEM-1:0]   exp_en;
    logic [NENT_W-1:0] exp_addr;
    logic [3:0]        exp_sel;
    v = '0;
    v[0*NENT_W +: NENT_W] = 6'd3;
    v[5*NENT_W +: NENT_W] = 6'd2;
    run_event(v, 12, -1, '0);
    for (int c = 0; c < 12; c++) begin
      exp_en = (c >= 1 && c <= 3) ? 12'h001 : ((c >= 4 && c <= 5) ? 12'h020 : 12'h000);
      checks++; if (lg_rd_en[c] !== exp_en) begin errors++; $display("FAIL basic_rd_en cyc %0d got %h exp %h", c, lg_rd_en[c], exp_en); end
      if (c >= 1 && c <= 5) begin
        exp_addr = (c <= 3) ? NENT_W'(c - 1) : NENT_W'(c - 4);
        checks++; if (lg_addr[c] !== exp_addr) begin errors++; $display("FAIL basic_addr cyc %0d got %0d exp %0d", c, lg_addr[c], exp_addr); end
      end
      if (c >= 2 && c <= 6) begin
        exp_sel = (c <= 4) ? 4'h0 : 4'h5;
        checks++; if (lg_sel[c] !== exp_sel) begin errors++; $display("FAIL basic_sel cyc %0d got %h exp %h", c, lg_sel[c], exp_sel); end
      end
      checks++; if (lg_val[c] !== (c >= 3 && c <= 7)) begin errors++; $display("FAIL basic_valid cyc %0d got %b", c, lg_val[c]); end
      checks++; if (lg_last[c] !== (c == 7)) begin errors++; $display("FAIL basic_last cyc %0d got %b", c, lg_last[c]); end
      checks++; if (lg_busy[c] !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL basic_busy cyc %0d got %b", c, lg_busy[c]); end
    end
    checks++; if (lg_trunc[11] !== 1'b0) begin errors++; $display("FAIL basic_trunc got %b exp 0", lg_trunc[11]); end
    $display("basic: mem0=3 mem5=2, 5 words issued");
  endtask

  task automatic test_sel_codes();
    logic [VW-1:0] v;
    v = '0;
    v[10*NENT_W +: NENT_W] = 6'd1;
    v[11*NENT_W +: NENT_W] = 6'd1;
    run_event(v, 8, -1, '0);
    checks++; if (lg_rd_en[1] !== 12'h400) begin errors++; $display("FAIL sel_rd_en1 got %h exp 400", lg_rd_en[1]); end
    checks++; if (lg_rd_en[2] !== 12'h800) begin errors++; $display("FAIL sel_rd_en2 got %h exp 800", lg_rd_en[2]); end
    checks++; if (lg_addr[2] !== 6'd0) begin errors++; $display("FAIL sel_addr2 got %0d exp 0", lg_addr[2]); end
    checks++; if (lg_sel[2] !== 4'hB) begin errors++; $display("FAIL sel_code10 got %h exp b", lg_sel[2]); end
    checks++; if (lg_sel[3] !== 4'hC) begin errors++; $display("FAIL sel_code11 got %h exp c", lg_sel[3]); end
    checks++; if (lg_sel[6] !== 4'hC) begin errors++; $display("FAIL sel_hold got %h exp c", lg_sel[6]); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (lg_sel[c] === 4'hA) begin errors++; $display("FAIL sel_hole cyc %0d got a", c); end
    end
    checks++; if (lg_val[3] !== 1'b1 || lg_val[4] !== 1'b1 || lg_val[5] !== 1'b0) begin errors++; $display("FAIL sel_valid got %b%b%b exp 110", lg_val[3], lg_val[4], lg_val[5]); end
    checks++; if (lg_last[3] !== 1'b0 || lg_last[4] !== 1'b1) begin errors++; $display("FAIL sel_last got %b%b exp 01", lg_last[3], lg_last[4]); end
    $display("sel_codes: mem10 then mem11 -> b, c");
  endtask

  task automatic test_budget();
    logic [VW-1:0]     v;
    logic [NMEM-1:0]   exp_en;
    logic [NENT_W-1:0] exp_addr;
    int                nissue;
    int                nvalid;
    for (int m = 0; m < NMEM; m++) v[m*NENT_W +: NENT_W] = 6'd20;
    run_event(v, 115, -1, '0);
    nissue = 0;
    nvalid = 0;
    for (int c = 0; c < 115; c++) begin
      exp_en = '0;
      if (c >= 1 && c <= 108) exp_en[(c - 1) / 20] = 1'b1;
      checks++; if (lg_rd_en[c] !== exp_en) begin errors++; $display("FAIL budget_rd_en cyc %0d got %h exp %h", c, lg_rd_en[c], exp_en); end
      if (c >= 1 && c <= 108) begin
        exp_addr = NENT_W'((c - 1) % 20);
        checks++; if (lg_addr[c] !== exp_addr) begin errors++; $display("FAIL budget_addr cyc %0d got %0d exp %0d", c, lg_addr[c], exp_addr); end
      end
      if (lg_rd_en[c] !== 12'h000) nissue++;
      if (lg_val[c] === 1'b1) nvalid++;
      checks++; if (lg_last[c] !== (c == 110)) begin errors++; $display("FAIL budget_last cyc %0d got %b", c, lg_last[c]); end
    end
    checks++; if (nissue != 108) begin errors++; $display("FAIL budget_issues got %0d exp 108", nissue); end
    checks++; if (nvalid != 108) begin errors++; $display("FAIL budget_valids got %0d exp 108", nvalid); end
    checks++; if (lg_val[3] !== 1'b1 || lg_val[110] !== 1'b1 || lg_val[111] !== 1'b0) begin errors++; $display("FAIL budget_valid_span got %b%b%b exp 110", lg_val[3], lg_val[110], lg_val[111]); end
    checks++; if (lg_busy[108] !== 1'b1 || lg_busy[109] !== 1'b0) begin errors++; $display("FAIL budget_busy got %b%b exp 10", lg_busy[108], lg_busy[109]); end
    checks++; if (lg_trunc[114] !== 1'b1) begin errors++; $display("FAIL budget_trunc got %b exp 1", lg_trunc[114]); end
    $display("budget: 240 entries, %0d issued, %0d valid", nissue, nvalid);
  endtask

  task automatic test_abort();
    logic [VW-1:0]     v;
    logic [VW-1:0]     v2;
    logic [NMEM-1:0]   exp_en;
    logic [NENT_W-1:0] exp_addr;
    for (int m = 0; m < NMEM; m++) v[m*NENT_W +: NENT_W] = 6'd20;
    v2 = '0;
    v2[0*NENT_W +: NENT_W] = 6'd2;
    v2[3*NENT_W +: NENT_W] = 6'd1;
    run_event(v, 60, 50, v2);
    for (int c = 0; c < 60; c++) begin
      exp_en   = '0;
      exp_addr = '0;
      if (c >= 1 && c <= 50) begin
        exp_en[(c - 1) / 20] = 1'b1;
        exp_addr = NENT_W'((c - 1) % 20);
      end else if (c == 51 || c == 52) begin
        exp_en[0] = 1'b1;
        exp_addr  = NENT_W'(c - 51);
      end else if (c == 53) begin
        exp_en[3] = 1'b1;
      end
      checks++; if (lg_rd_en[c] !== exp_en) begin errors++; $display("FAIL abort_rd_en cyc %0d got %h exp %h", c, lg_rd_en[c], exp_en); end
      if (exp_en != '0) begin
        checks++; if (lg_addr[c] !== exp_addr) begin errors++; $display("FAIL abort_addr cyc %0d got %0d exp %0d", c, lg_addr[c], exp_addr); end
      end
      checks++; if (lg_val[c] !== (c >= 3 && c <= 55)) begin errors++; $display("FAIL abort_valid cyc %0d got %b", c, lg_val[c]); end
      checks++; if (lg_last[c] !== (c == 55)) begin errors++; $display("FAIL abort_last cyc %0d got %b", c, lg_last[c]); end
    end
    checks++; if (lg_sel[51] !== 4'h2 || lg_sel[52] !== 4'h0 || lg_sel[54] !== 4'h3) begin errors++; $display("FAIL abort_sel got %h %h %h exp 2 0 3", lg_sel[51], lg_sel[52], lg_sel[54]); end
    checks++; if (lg_trunc[1] !== 1'b0 || lg_trunc[50] !== 1'b0) begin errors++; $display("FAIL abort_trunc_pre got %b%b exp 00", lg_trunc[1], lg_trunc[50]); end
    checks++; if (lg_trunc[51] !== 1'b1 || lg_trunc[59] !== 1'b1) begin errors++; $display("FAIL abort_trunc_post got %b%b exp 11", lg_trunc[51], lg_trunc[59]); end
    checks++; if (lg_busy[53] !== 1'b1 || lg_busy[54] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b%b exp 10", lg_busy[53], lg_busy[54]); end
    $display("abort: restart at cycle 50 with mem0=2 mem3=1");
  endtask

  task automatic test_zero();
    run_event('0, 8, -1, '0);
    for (int c = 0; c < 8; c++) begin
      checks++; if (lg_busy[c] !== 1'b0 || lg_rd_en[c] !== 12'h000 || lg_val[c] !== 1'b0) begin errors++; $display("FAIL zero_idle cyc %0d got busy=%b rd_en=%h valid=%b exp all 0", c, lg_busy[c], lg_rd_en[c], lg_val[c]); end
    end
    checks++; if (lg_trunc[7] !== 1'b0) begin errors++; $display("FAIL zero_trunc got %b exp 0", lg_trunc[7]); end
    $display("zero: empty event, no reads");
  endtask

  task automatic test_reset_mid_run();
    logic [VW-1:0] v;
    v = '0;
    v[3*NENT_W +: NENT_W] = 6'd10;
    bus.nent_all = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    checks++; if (bus.rd_en !== 12'h008 || bus.rd_addr !== 6'd3 || bus.sel !== 4'h3) begin errors++; $display("FAIL midrst_pre got rd_en=%h addr=%0d sel=%h exp 008 3 3", bus.rd_en, bus.rd_addr, bus.sel); end
    reset = 1'b1;
    step();
    checks++; if (bus.rd_en !== 12'h000) begin errors++; $display("FAIL midrst_rd_en got %h exp 000", bus.rd_en); end
    checks++; if (bus.rd_addr !== 6'd0) begin errors++; $display("FAIL midrst_addr got %0d exp 0", bus.rd_addr); end
    checks++; if (bus.sel !== 4'h0) begin errors++; $display("FAIL midrst_sel got %h exp 0", bus.sel); end
    checks++; if (bus.dat_valid !== 1'b0 || bus.dat_last !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b%b exp 00", bus.dat_valid, bus.dat_last); end
    checks++; if (bus.busy !== 1'b0 || bus.truncated !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b%b exp 00", bus.busy, bus.truncated); end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (bus.dat_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_drop step %0d got valid=%b busy=%b exp 0 0", c, bus.dat_valid, bus.busy); end
    end
    v[3*NENT_W +: NENT_W] = 6'd2;
    run_event(v, 8, -1, '0);
    checks++; if (lg_rd_en[1] !== 12'h008 || lg_addr[1] !== 6'd0) begin errors++; $display("FAIL midrst_restart1 got %h/%0d exp 008/0", lg_rd_en[1], lg_addr[1]); end
    checks++; if (lg_rd_en[2] !== 12'h008 || lg_addr[2] !== 6'd1) begin errors++; $display("FAIL midrst_restart2 got %h/%0d exp 008/1", lg_rd_en[2], lg_addr[2]); end
    checks++; if (lg_sel[2] !== 4'h3) begin errors++; $display("FAIL midrst_sel got %h exp 3", lg_sel[2]); end
    checks++; if (lg_val[3] !== 1'b1 || lg_val[4] !== 1'b1 || lg_last[4] !== 1'b1 || lg_val[5] !== 1'b0) begin errors++; $display("FAIL midrst_stream got v3=%b v4=%b l4=%b v5=%b exp 1 1 1 0", lg_val[3], lg_val[4], lg_last[4], lg_val[5]); end
    $display("reset_mid_run: readout dropped, restart of mem3=2 ok");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_codes();
    test_budget();
    test_abort();
    test_zero();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
